conversion_controller: RTL
==========================

CONVERSION_CONTROLLER -- requirements
Module: conversion_controller

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of comparator synchronizer flops (legal range 2..4).
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  conversion request; sampled in IDLE only.
- abort_i  in  1  synchronous abort.
- az_limit_i  in  16  auto-zero phase terminal count.
- int_limit_i  in  16  integrate phase terminal count.
- deint_limit_i  in  16  de-integrate timeout count.
- cmp_i  in  1  asynchronous integrator comparator; 1 = integrator above zero.
- cnt_en_o  out  1  timing counter enable.
- cnt_clear_o  out  1  timing counter clear.
- cnt_limit_o  out  16  timing counter limit.
- cnt_busy_i  in  1  timing counter busy.
- cnt_done_i  in  1  timing counter single-cycle done pulse.
- cnt_count_i  in  16  timing counter value.
- sw_az_o  out  1  auto-zero switch.
- sw_vin_o  out  1  input switch.
- sw_vref_o  out  1  reference switch.
- busy_o  out  1  conversion in progress.
- result_o  out  16  de-integrate count.
- overrange_o  out  1  timeout flag.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  result consumed.

Function
REQ-003 SHALL implement the states IDLE, GAP, AZ, INT, DEINT and RESULT; GAP is a one-cycle break-before-make state entered before each of AZ, INT and DEINT, with the next phase held in a register.
REQ-004 SHALL, in GAP, drive cnt_en_o=0, cnt_clear_o=1 and all switches 0, so the counter restarts from 0 when the phase begins.
REQ-005 SHALL, in AZ, INT and DEINT, drive cnt_en_o=1 and cnt_clear_o=0, and drive cnt_limit_o to az_limit_i, int_limit_i or deint_limit_i respectively.
REQ-006 SHALL keep sw_az_o, sw_vin_o and sw_vref_o registered and at most one of them high; each is 1 only in AZ, INT or DEINT respectively.
REQ-007 SHALL, in IDLE with start_i=1 and result_valid_o=0, go to GAP toward AZ; start_i SHALL be ignored in every other state and while result_valid_o=1.
REQ-008 SHALL, in AZ, advance to GAP toward INT on cnt_done_i; in INT, advance on cnt_done_i to GAP toward DEINT if cmp_s=1, otherwise load result_o=0, overrange_o=0 and go to RESULT.
REQ-009 SHALL synchronize cmp_i through SYNC_STAGES flops to cmp_s; a zero crossing is cmp_s=0 in DEINT while cnt_busy_i=1.
REQ-010 SHALL, in DEINT on a zero crossing, load result_o=cnt_count_i and overrange_o=0, then go to RESULT.
REQ-011 SHALL, in DEINT on cnt_done_i with no zero crossing, load result_o=deint_limit_i and overrange_o=1, then go to RESULT.
REQ-012 SHALL give the zero crossing priority when it coincides with cnt_done_i (overrange_o=0).
REQ-013 SHALL, in RESULT, hold result_valid_o=1 with result_o and overrange_o stable, and drive cnt_en_o=0; when result_valid_o and result_ready_i are both 1, it SHALL return to IDLE and clear result_valid_o the next cycle.
REQ-014 SHALL drive busy_o=1 in GAP, AZ, INT and DEINT, and 0 in IDLE and RESULT.
REQ-015 SHALL, on abort_i=1 in any state other than IDLE, go to IDLE next cycle with switches 0, cnt_en_o=0, result_valid_o=0 and result_o unchanged; abort_i has priority over every other event.
REQ-016 SHALL ignore cnt_done_i in IDLE, GAP and RESULT.

Reset
REQ-017 SHALL, while rst_ni=0, asynchronously force state IDLE and set all outputs and synchronizer flops to 0.
REQ-018 SHALL, on reset mid-conversion, open all switches immediately and discard the conversion without producing a result.

Configuration
REQ-019 SHALL, with VM_AUTOZERO_EN defined, include AZ as specified.
REQ-020 SHALL, without VM_AUTOZERO_EN, omit AZ: start goes to GAP toward INT, az_limit_i is unused and sw_az_o is tied to 0.

Verification
REQ-021 Full conversion: az=4, int=10, deint=100, cmp drops 20 cycles into DEINT -> switch order az, vin, vref with a one-cycle all-off gap between each; result_valid_o=1, overrange_o=0, result_o equals cnt_count_i at the zero crossing.
REQ-022 Timeout: cmp_i held 1, deint=50 -> result_o=50, overrange_o=1.
REQ-023 Coincidence: cmp_s falls in the same cycle as cnt_done_i in DEINT -> overrange_o=0, result_o=cnt_count_i.
REQ-024 Negative input: cmp_i=0 at the end of INT -> no DEINT, result_o=0, sw_vref_o never 1.
REQ-025 Backpressure and abort: result_ready_i held 0 for 30 cycles -> result_valid_o and result_o stable and start_i ignored; abort_i during INT -> IDLE next cycle with switches 0.
REQ-026 Reset: rst_ni pulsed low mid-DEINT -> all outputs 0 immediately; compile without VM_AUTOZERO_EN -> sw_az_o never 1 and the first phase is INT.

Source files
------------

// File: rtl/conversion_controller.sv
// Dual-slope ADC conversion sequencer: auto-zero, integrate, de-integrate with break-before-make gaps.
// Define VM_AUTOZERO_EN to build the auto-zero phase; without it a conversion starts with integrate.
module conversion_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] az_limit_i,
    input  logic [15:0] int_limit_i,
    input  logic [15:0] deint_limit_i,
    input  logic        cmp_i,
    output logic        cnt_en_o,
    output logic        cnt_clear_o,
    output logic [15:0] cnt_limit_o,
    input  logic        cnt_busy_i,
    input  logic        cnt_done_i,
    input  logic [15:0] cnt_count_i,
    output logic        sw_az_o,
    output logic        sw_vin_o,
    output logic        sw_vref_o,
    output logic        busy_o,
    output logic [15:0] result_o,
    output logic        overrange_o,
    output logic        result_valid_o,
    input  logic        result_ready_i
);

    // state    | meaning
    // IDLE     | waiting for start_i, switches open
    // GAP      | one-cycle break-before-make, counter cleared, phase holds the target
    // AZ       | auto-zero switch closed, counting az_limit_i
    // INT      | input switch closed, counting int_limit_i
    // DEINT    | reference switch closed until zero crossing or deint_limit_i timeout
    // RESULT   | result_o/overrange_o presented until result_ready_i
    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_AZ, S_INT, S_DEINT, S_RESULT
    } state_t;

`ifdef VM_AUTOZERO_EN
    localparam state_t FIRST_PHASE = S_AZ;
`else
    localparam state_t FIRST_PHASE = S_INT;
    logic unused_az;
    assign unused_az = ^az_limit_i;
`endif

    state_t state, state_d, phase, phase_d, limit_sel;
    logic [SYNC_STAGES-1:0] cmp_sync;
    logic        cmp_s;
    logic        zero_x;
    logic [15:0] result_d;
    logic [15:0] limit_d;
    logic        ovr_d;

    assign cmp_s  = cmp_sync[SYNC_STAGES-1];
    assign zero_x = (state == S_DEINT) && cnt_busy_i && !cmp_s;

    always_comb begin
        state_d  = state;
        phase_d  = phase;
        result_d = result_o;
        ovr_d    = overrange_o;
        if (abort_i && state != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !result_valid_o) begin
                        state_d = S_GAP;
                        phase_d = FIRST_PHASE;
                    end
                end
                S_GAP: state_d = phase;
`ifdef VM_AUTOZERO_EN
                S_AZ: begin
                    if (cnt_done_i) begin
                        state_d = S_GAP;
                        phase_d = S_INT;
                    end
                end
`endif
                S_INT: begin
                    if (cnt_done_i) begin
                        if (cmp_s) begin
                            state_d = S_GAP;
                            phase_d = S_DEINT;
                        end else begin
                            // integrator already below zero: nothing to de-integrate
                            state_d  = S_RESULT;
                            result_d = '0;
                            ovr_d    = 1'b0;
                        end
                    end
                end
                S_DEINT: begin
                    if (zero_x) begin
                        state_d  = S_RESULT;
                        result_d = cnt_count_i;
                        ovr_d    = 1'b0;
                    end else if (cnt_done_i) begin
                        state_d  = S_RESULT;
                        result_d = deint_limit_i;
                        ovr_d    = 1'b1;
                    end
                end
                S_RESULT: begin
                    if (result_valid_o && result_ready_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // limit is loaded during GAP so the counter sees it from the first phase cycle
    always_comb begin
        limit_d   = cnt_limit_o;
        limit_sel = (state_d == S_GAP) ? phase_d : state_d;
        case (limit_sel)
`ifdef VM_AUTOZERO_EN
            S_AZ:    limit_d = az_limit_i;
`endif
            S_INT:   limit_d = int_limit_i;
            S_DEINT: limit_d = deint_limit_i;
            default: limit_d = cnt_limit_o;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= S_IDLE;
            phase          <= S_IDLE;
            cmp_sync       <= '0;
            cnt_en_o       <= 1'b0;
            cnt_clear_o    <= 1'b0;
            cnt_limit_o    <= '0;
            sw_vin_o       <= 1'b0;
            sw_vref_o      <= 1'b0;
            busy_o         <= 1'b0;
            result_o       <= '0;
            overrange_o    <= 1'b0;
            result_valid_o <= 1'b0;
        end else begin
            state          <= state_d;
            phase          <= phase_d;
            cmp_sync       <= {cmp_sync[SYNC_STAGES-2:0], cmp_i};
            cnt_en_o       <= (state_d == S_AZ) || (state_d == S_INT) || (state_d == S_DEINT);
            cnt_clear_o    <= (state_d == S_GAP);
            cnt_limit_o    <= limit_d;
            sw_vin_o       <= (state_d == S_INT);
            sw_vref_o      <= (state_d == S_DEINT);
            busy_o         <= (state_d != S_IDLE) && (state_d != S_RESULT);
            result_o       <= result_d;
            overrange_o    <= ovr_d;
            result_valid_o <= (state_d == S_RESULT);
        end
    end

`ifdef VM_AUTOZERO_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sw_az_o <= 1'b0;
        else         sw_az_o <= (state_d == S_AZ);
    end
`else
    assign sw_az_o = 1'b0;
`endif

endmodule
